// File: rtl/mp_issue_ctrl.sv
// Issue sequencer for mp_top: FIFO-buffered, drops bad opcodes, one instruction in flight; result HOLD+LATENCY+1 cycles after pop.
// Backpressure: in_ready falls when the FIFO is full or during flush; FIFO keeps accepting while the FSM is busy.
module mp_issue_ctrl #(
    parameter int DEPTH   = 8,
    parameter int HOLD    = 1,
    parameter int LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic [31:0]              mp_instr,
    input  logic [31:0]              mp_result,
    output logic                     res_valid,
    output logic [31:0]              res_data,
    output logic [5:0]               res_opcode,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               invalid_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q;
    logic [3:0]    timer_q;
    logic [31:0]   mp_instr_q;
    logic [5:0]    op_q;
    logic          res_valid_q;
    logic [31:0]   res_data_q;
    logic [5:0]    res_opcode_q;
    logic [7:0]    invalid_cnt_q;

    logic          full, empty, push, pop;
    logic [31:0]   head;
    logic [5:0]    head_op;

    function automatic logic op_valid(input logic [5:0] op);
        case (op)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd11, 6'd13, 6'd15: op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr_q];
    assign head_op  = head[5:0];
    // Every head seen in IDLE leaves the FIFO: valid ones issue, invalid ones are dropped.
    assign pop      = (state_q == S_IDLE) && !empty && !flush;

    always_comb begin
        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            mp_instr_q    <= '0;
            op_q          <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_opcode_q  <= '0;
            invalid_cnt_q <= '0;
        end else begin
            res_valid_q <= 1'b0;
            if (flush) begin
                // Abandon any in-flight instruction; result and drop counter are kept.
                state_q    <= S_IDLE;
                timer_q    <= '0;
                mp_instr_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!empty) begin
                            if (op_valid(head_op)) begin
                                mp_instr_q <= head;
                                op_q       <= head_op;
                                timer_q    <= 4'(HOLD);
                                state_q    <= S_ISSUE;
                            end else if (invalid_cnt_q != 8'hFF) begin
                                invalid_cnt_q <= invalid_cnt_q + 8'd1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (timer_q == 4'd1) begin
                            mp_instr_q <= '0;
                            timer_q    <= 4'(LATENCY);
                            state_q    <= S_WAIT;
                        end else begin
                            timer_q <= timer_q - 4'd1;
                        end
                    end
                    S_WAIT: begin
                        if (timer_q == 4'd1)
                            state_q <= S_CAPTURE;
                        else
                            timer_q <= timer_q - 4'd1;
                    end
                    S_CAPTURE: begin
                        res_data_q   <= mp_result;
                        res_opcode_q <= op_q;
                        res_valid_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign mp_instr    = mp_instr_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_opcode  = res_opcode_q;
    assign invalid_cnt = invalid_cnt_q;
    assign fifo_count  = count_q;
    assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_mp_issue_ctrl.sv
// Directed bench for mp_issue_ctrl with a stand-in mp_top whose result is the issued word XOR a key.
module tb_mp_issue_ctrl;

    localparam logic [31:0] KEY = 32'h00034D11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] mp_instr;
    logic [31:0] mp_result;
    logic        res_valid;
    logic [31:0] res_data;
    logic [5:0]  res_opcode;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [7:0]  invalid_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    logic [31:0] mp_last = '0;
    logic [31:0] rq_data [$];
    logic [5:0]  rq_op   [$];
    int          rq_cyc  [$];

    mp_issue_ctrl #(.DEPTH(8), .HOLD(1), .LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .mp_instr(mp_instr), .mp_result(mp_result),
        .res_valid(res_valid), .res_data(res_data), .res_opcode(res_opcode),
        .busy(busy), .fifo_count(fifo_count), .invalid_cnt(invalid_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mp_instr != 32'h0) mp_last <= mp_instr;
    end
    assign mp_result = mp_last ^ KEY;

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid) begin
                rq_data.push_back(res_data);
                rq_op.push_back(res_opcode);
                rq_cyc.push_back(cyc);
            end
            if (mp_instr != 32'h0) issue_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_instr = '0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push_instr(input logic [31:0] instr, output int push_cyc);
        int guard = 0;
        in_valid = 1'b1;
        in_instr = instr;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        push_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int budget);
        int guard = 0;
        while (rq_data.size() < target && guard < budget) begin
            step();
            guard++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (mp_instr !== 32'h0)   begin errors++; $display("FAIL reset_mp_instr got %h want 0", mp_instr); end
        checks++; if (res_valid !== 1'b0)   begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (res_data !== 32'h0)   begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fifo_count !== 4'd0)  begin errors++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
        checks++; if (invalid_cnt !== 8'd0) begin errors++; $display("FAIL reset_invalid_cnt got %0d want 0", invalid_cnt); end
    endtask

    task automatic test_single_add();
        int pc;
        int n0;
        int i0;
        do_reset();
        n0 = rq_data.size();
        i0 = issue_cnt;
        push_instr(32'h00031041, pc);
        wait_results(n0 + 1, 30);
        checks++;
        if (rq_data.size() != n0 + 1) begin
            errors++; $display("FAIL add_result_count got %0d want 1", rq_data.size() - n0);
        end else begin
            checks++; if (rq_cyc[n0] - pc != 6)   begin errors++; $display("FAIL add_latency got %0d want 6", rq_cyc[n0] - pc); end
            checks++; if (rq_data[n0] !== 32'h5D50) begin errors++; $display("FAIL add_res_data got %h want 00005d50", rq_data[n0]); end
            checks++; if (rq_op[n0] !== 6'd1)     begin errors++; $display("FAIL add_res_opcode got %0d want 1", rq_op[n0]); end
        end
        step();
        checks++; if (res_valid !== 1'b0)       begin errors++; $display("FAIL add_strobe_width got %b want 0", res_valid); end
        checks++; if (issue_cnt - i0 != 1)      begin errors++; $display("FAIL add_issue_cycles got %0d want 1", issue_cnt - i0); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops [10] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd11, 6'd13};
        logic [31:0] v   [10];
        int i = 0;
        int guard = 0;
        int n0;
        do_reset();
        n0 = rq_data.size();
        for (int k = 0; k < 10; k++)
            v[k] = {11'b0, 5'(k + 3), 5'(k + 2), 5'(k + 1), ops[k]};
        while (i < 10 && guard < 200) begin
            logic rdy;
            in_valid = 1'b1;
            in_instr = v[i];
            rdy = in_ready;
            step();
            if (rdy) i++;
            guard++;
        end
        in_valid = 1'b0;
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL b2b_full_count got %0d want 8", fifo_count); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL b2b_full_ready got %b want 0", in_ready); end
        wait_results(n0 + 10, 200);
        checks++;
        if (rq_data.size() != n0 + 10) begin
            errors++; $display("FAIL b2b_result_count got %0d want 10", rq_data.size() - n0);
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (rq_data[n0 + k] !== (v[k] ^ KEY) || rq_op[n0 + k] !== ops[k]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got %h/%0d want %h/%0d", k, rq_data[n0 + k], rq_op[n0 + k], v[k] ^ KEY, ops[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (rq_cyc[n0 + k] - rq_cyc[n0 + k - 1] != 6) begin
                        errors++; $display("FAIL b2b_spacing[%0d] got %0d want 6", k, rq_cyc[n0 + k] - rq_cyc[n0 + k - 1]);
                    end
                end
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after got %b want 0", busy); end
        end
    endtask

    task automatic test_invalid_mix();
        int pc;
        int n0;
        logic [31:0] sub_i = 32'h0001_0846;
        do_reset();
        n0 = rq_data.size();
        in_valid = 1'b1;
        in_instr = 32'h0000_107F;
        step();
        in_instr = 32'h0000_1040;
        step();
        in_valid = 1'b0;
        push_instr(sub_i, pc);
        wait_results(n0 + 1, 30);
        repeat (10) step();
        checks++; if (invalid_cnt !== 8'd2)      begin errors++; $display("FAIL mix_invalid_cnt got %0d want 2", invalid_cnt); end
        checks++;
        if (rq_data.size() != n0 + 1) begin
            errors++; $display("FAIL mix_result_count got %0d want 1", rq_data.size() - n0);
        end else begin
            checks++; if (rq_op[n0] !== 6'd6)             begin errors++; $display("FAIL mix_res_opcode got %0d want 6", rq_op[n0]); end
            checks++; if (rq_data[n0] !== (sub_i ^ KEY))  begin errors++; $display("FAIL mix_res_data got %h want %h", rq_data[n0], sub_i ^ KEY); end
        end
    endtask

    task automatic test_saturation();
        int n0;
        int i0;
        do_reset();
        n0 = rq_data.size();
        i0 = issue_cnt;
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b1;
            in_instr = {26'(k), (k % 2 == 0) ? 6'h3F : 6'h09};
            step();
            if (k == 99) begin
                checks++; if (invalid_cnt !== 8'd99) begin errors++; $display("FAIL sat_mid_count got %0d want 99", invalid_cnt); end
            end
        end
        in_valid = 1'b0;
        repeat (3) step();
        checks++; if (invalid_cnt !== 8'hFF)       begin errors++; $display("FAIL sat_invalid_cnt got %0d want 255", invalid_cnt); end
        checks++; if (rq_data.size() != n0)        begin errors++; $display("FAIL sat_res_valid got %0d want 0", rq_data.size() - n0); end
        checks++; if (issue_cnt != i0)             begin errors++; $display("FAIL sat_mp_instr got %0d want 0", issue_cnt - i0); end
        checks++; if (fifo_count !== 4'd0)         begin errors++; $display("FAIL sat_fifo_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_flush();
        int n0;
        int i0;
        int pc;
        logic [31:0] nxt = 32'h0002_1087;
        do_reset();
        n0 = rq_data.size();
        i0 = issue_cnt;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_instr = {11'b0, 5'd4, 5'(k), 5'd1, 6'd3};
            step();
        end
        in_valid = 1'b0;
        checks++; if (fifo_count !== 4'd3)      begin errors++; $display("FAIL flush_pre_count got %0d want 3", fifo_count); end
        checks++; if (issue_cnt - i0 != 1 || mp_instr !== 32'h0) begin
            errors++; $display("FAIL flush_pre_wait got issues %0d mp_instr %h want 1/0", issue_cnt - i0, mp_instr);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0000_0001;
        #1;
        checks++; if (in_ready !== 1'b0)        begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 4'd0)      begin errors++; $display("FAIL flush_count got %0d want 0", fifo_count); end
        checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        checks++; if (mp_instr !== 32'h0)       begin errors++; $display("FAIL flush_mp_instr got %h want 0", mp_instr); end
        repeat (12) step();
        checks++; if (rq_data.size() != n0)     begin errors++; $display("FAIL flush_res_valid got %0d want 0", rq_data.size() - n0); end
        push_instr(nxt, pc);
        wait_results(n0 + 1, 30);
        checks++;
        if (rq_data.size() != n0 + 1) begin
            errors++; $display("FAIL flush_next_count got %0d want 1", rq_data.size() - n0);
        end else begin
            checks++; if (rq_cyc[n0] - pc != 6 || rq_data[n0] !== (nxt ^ KEY)) begin
                errors++; $display("FAIL flush_next got lat %0d data %h want 6 %h", rq_cyc[n0] - pc, rq_data[n0], nxt ^ KEY);
            end
        end
    endtask

    task automatic test_async_reset();
        int pc;
        int n0;
        int i0;
        int guard = 0;
        logic [31:0] a = 32'h0000_0845;
        do_reset();
        n0 = rq_data.size();
        push_instr(a, pc);
        wait_results(n0 + 1, 30);
        in_valid = 1'b1;
        in_instr = 32'h0000_003F;
        step();
        in_instr = 32'h0000_1042;
        step();
        in_instr = 32'h0000_1043;
        step();
        in_valid = 1'b0;
        while (mp_instr == 32'h0 && guard < 20) begin
            step();
            guard++;
        end
        checks++; if (mp_instr !== 32'h0000_1042)   begin errors++; $display("FAIL ares_pre_issue got %h want 00001042", mp_instr); end
        checks++; if (invalid_cnt !== 8'd1 || res_data !== (a ^ KEY)) begin
            errors++; $display("FAIL ares_pre_state got %0d/%h want 1/%h", invalid_cnt, res_data, a ^ KEY);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mp_instr !== 32'h0)      begin errors++; $display("FAIL ares_mp_instr got %h want 0", mp_instr); end
        checks++; if (res_data !== 32'h0 || res_opcode !== 6'd0) begin
            errors++; $display("FAIL ares_res got %h/%0d want 0/0", res_data, res_opcode);
        end
        checks++; if (invalid_cnt !== 8'd0)    begin errors++; $display("FAIL ares_invalid_cnt got %0d want 0", invalid_cnt); end
        checks++; if (fifo_count !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL ares_fifo got %0d busy %b want 0/0", fifo_count, busy);
        end
        step();
        step();
        rst_n = 1'b1;
        n0 = rq_data.size();
        i0 = issue_cnt;
        repeat (20) step();
        checks++; if (rq_data.size() != n0)    begin errors++; $display("FAIL ares_res_valid got %0d want 0", rq_data.size() - n0); end
        checks++; if (issue_cnt != i0)         begin errors++; $display("FAIL ares_issue got %0d want 0", issue_cnt - i0); end
        checks++; if (fifo_count !== 4'd0)     begin errors++; $display("FAIL ares_count_after got %0d want 0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_invalid_mix();
        test_saturation();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
